// File: rtl/fp_mul_scheduler.sv
// fp_mul_scheduler: round-robin sharing of one FP multiplier core across NUM_REQ requesters, MUL_LAT-stage tagged pipeline
module fp_mul_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 2,
  parameter int ID_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_result,
  input  logic                   rsp_ready,
  output logic                   busy
);
  logic [MUL_LAT-1:0] vld;
  logic [31:0] res_q [MUL_LAT];
  logic [ID_W-1:0] id_q [MUL_LAT];
  logic [ID_W-1:0] last_grant, gnt_id, idx;
  logic found, advance, issue;
  logic [31:0] op_a, op_b, product;
  logic [47:0] prod;
  logic [7:0] exp_sum;
  logic unused;
  assign advance = !rsp_valid || rsp_ready;
  always_comb begin
    found = 1'b0;
    gnt_id = '0;
    idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt_id = idx;
      end
    end
  end
  assign req_ready = (found && advance && !rst) ? NUM_REQ'(1) << gnt_id : '0;
  assign issue = |req_ready;
  assign op_a = req_a[32*gnt_id +: 32];
  assign op_b = req_b[32*gnt_id +: 32];
  assign prod = 48'({1'b1, op_a[22:0]}) * 48'({1'b1, op_b[22:0]});
  assign exp_sum = op_a[30:23] + op_b[30:23] - 8'd127;
  assign product = {op_a[31] ^ op_b[31], prod[47] ? exp_sum + 8'd1 : exp_sum, prod[47] ? prod[46:24] : prod[45:23]};
  assign unused = ^prod[22:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      for (int k = 0; k < MUL_LAT; k++) begin
        res_q[k] <= '0;
        id_q[k] <= '0;
      end
    end else if (advance) begin
      vld[0] <= issue;
      if (issue) begin
        res_q[0] <= product;
        id_q[0] <= gnt_id;
        last_grant <= gnt_id;
      end
      for (int k = 1; k < MUL_LAT; k++) begin
        vld[k] <= vld[k-1];
        if (vld[k-1]) begin
          res_q[k] <= res_q[k-1];
          id_q[k] <= id_q[k-1];
        end
      end
    end
  end
  assign rsp_valid = vld[MUL_LAT-1];
  assign rsp_id = id_q[MUL_LAT-1];
  assign rsp_result = res_q[MUL_LAT-1];
  assign busy = |vld;
endmodule

// File: tb/tb_fp_mul_scheduler.sv
// tb_fp_mul_scheduler: directed self-checking bench for fp_mul_scheduler
module tb_fp_mul_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [3:0] req_ready;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic rsp_valid, busy;
  logic rsp_ready = 1'b1;
  logic [1:0] rsp_id;
  logic [31:0] rsp_result;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] bv [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  always #5 clk = ~clk;
  fp_mul_scheduler #(.NUM_REQ(4), .MUL_LAT(2), .ID_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_a(req_a),
    .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_result(rsp_result),
    .rsp_ready(rsp_ready),
    .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic put(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask
  initial begin
    @(negedge clk);
    req_valid = 4'b1111;
    repeat (3) step();
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);
    chk("rst_result", rsp_result, 32'h0);
    rst = 1'b0;
    req_valid = 4'b0000;
    step();
    put(2, 32'h40000000, 32'h40400000);
    req_valid = 4'b0100;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b0000;
    #1;
    chk("t1_valid_lat1", 32'(rsp_valid), 32'h0);
    chk("t1_busy", 32'(busy), 32'h1);
    step();
    chk("t1_valid", 32'(rsp_valid), 32'h1);
    chk("t1_id", 32'(rsp_id), 32'h2);
    chk("t1_result", rsp_result, 32'h40C00000);
    step();
    chk("t1_done", 32'(rsp_valid), 32'h0);
    chk("t1_idle", 32'(busy), 32'h0);
    put(0, 32'h3FC00000, 32'h3FC00000);
    put(3, 32'hC0000000, 32'h3F000000);
    req_valid = 4'b0001;
    #1;
    chk("t2_ready0", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b1000;
    #1;
    chk("t2_ready3", 32'(req_ready), 32'h8);
    step();
    req_valid = 4'b0000;
    chk("t2_valid0", 32'(rsp_valid), 32'h1);
    chk("t2_id0", 32'(rsp_id), 32'h0);
    chk("t2_norm", rsp_result, 32'h40100000);
    step();
    chk("t2_valid3", 32'(rsp_valid), 32'h1);
    chk("t2_id3", 32'(rsp_id), 32'h3);
    chk("t2_sign", rsp_result, 32'hBF800000);
    step();
    chk("t2_done", 32'(rsp_valid), 32'h0);
    for (int i = 0; i < 4; i++) put(i, 32'h3F800000, bv[i]);
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 8) chk($sformatf("t3_grant%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
      if (c >= 2) begin
        chk($sformatf("t3_valid%0d", c), 32'(rsp_valid), 32'h1);
        chk($sformatf("t3_id%0d", c), 32'(rsp_id), 32'((c - 2) % 4));
        chk($sformatf("t3_res%0d", c), rsp_result, bv[(c - 2) % 4]);
      end
      step();
    end
    req_valid = 4'b0000;
    #1;
    chk("t3_done", 32'(rsp_valid), 32'h0);
    req_valid = 4'b0110;
    #1;
    chk("t4_grant1", 32'(req_ready), 32'h2);
    step();
    #1;
    chk("t4_grant2", 32'(req_ready), 32'h4);
    step();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("t4_stall_ready%0d", c), 32'(req_ready), 32'h0);
      chk($sformatf("t4_stall_valid%0d", c), 32'(rsp_valid), 32'h1);
      chk($sformatf("t4_stall_id%0d", c), 32'(rsp_id), 32'h1);
      chk($sformatf("t4_stall_res%0d", c), rsp_result, bv[1]);
      chk($sformatf("t4_stall_busy%0d", c), 32'(busy), 32'h1);
      step();
    end
    rsp_ready = 1'b1;
    req_valid = 4'b0000;
    #1;
    chk("t4_rel_id1", 32'(rsp_id), 32'h1);
    chk("t4_rel_res1", rsp_result, bv[1]);
    step();
    chk("t4_rel_valid2", 32'(rsp_valid), 32'h1);
    chk("t4_rel_id2", 32'(rsp_id), 32'h2);
    chk("t4_rel_res2", rsp_result, bv[2]);
    step();
    chk("t4_drained", 32'(rsp_valid), 32'h0);
    for (int c = 0; c < 7; c++) begin
      if (c % 2 == 0 && c < 6) begin
        put(0, 32'h3F800000, bv[c / 2 + 1]);
        req_valid = 4'b0001;
      end else begin
        req_valid = 4'b0000;
      end
      #1;
      if (c % 2 == 0 && c < 6) chk($sformatf("t5_ready%0d", c), 32'(req_ready), 32'h1);
      if (c >= 2) begin
        chk($sformatf("t5_valid%0d", c), 32'(rsp_valid), 32'(c % 2 == 0));
        if (c % 2 == 0) begin
          chk($sformatf("t5_id%0d", c), 32'(rsp_id), 32'h0);
          chk($sformatf("t5_res%0d", c), rsp_result, bv[(c - 2) / 2 + 1]);
        end
      end
      if (c == 6) chk("t5_busy_last", 32'(busy), 32'h1);
      step();
    end
    chk("t5_busy_drop", 32'(busy), 32'h0);
    chk("t5_valid_end", 32'(rsp_valid), 32'h0);
    req_valid = 4'b0110;
    #1;
    chk("t6_grant1", 32'(req_ready), 32'h2);
    step();
    #1;
    chk("t6_grant2", 32'(req_ready), 32'h4);
    step();
    rsp_ready = 1'b0;
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("t6_rst_ready", 32'(req_ready), 32'h0);
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b0000;
    #1;
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_id", 32'(rsp_id), 32'h0);
    chk("t6_res", rsp_result, 32'h0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("t6_valid%0d", c), 32'(rsp_valid), 32'h0);
      step();
    end
    req_valid = 4'b1111;
    #1;
    chk("t6_grant0", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0000;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fp_mul_scheduler.md
# fp_mul_scheduler

Shares one `fp_multiplier` core between `NUM_REQ` requesters. Each requester has its own valid/ready handshake. A round-robin arbiter selects one request per cycle and issues it into a `MUL_LAT`-stage registered pipeline wrapped around the combinational core. Results return on a single tagged response port with backpressure. The block sits between the per-lane operand producers and the FP writeback path.

## Interface

**Parameters**
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `MUL_LAT`, default 2: pipeline stages from issue to `rsp_valid`, at least 1.
- `ID_W`, default 2: tag width, equal to clog2(`NUM_REQ`).

**Ports**
- `clk`  in  1  single clock. All logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`  bit i means requester i holds an operand pair.
- `req_a`  in  32*`NUM_REQ`  operand A for requester i, in bits [32i+31:32i], IEEE-754 single.
- `req_b`  in  32*`NUM_REQ`  operand B for requester i, same packing.
- `req_ready`  out  `NUM_REQ`  one-hot or zero. Bit i means requester i is accepted this cycle.
- `rsp_valid`  out  1  result available.
- `rsp_id`  out  `ID_W`  index of the requester that issued this result.
- `rsp_result`  out  32  product.
- `rsp_ready`  in  1  consumer accepts the result.
- `busy`  out  1  at least one pipeline stage holds a valid entry.

## Operation

- **Transfer rules.** Request transfer: `req_valid[i] && req_ready[i]`. Response transfer: `rsp_valid && rsp_ready`.
- **Pipeline advance.** `advance = !rsp_valid || rsp_ready`. The whole pipeline moves together. When `advance` is 0 every stage holds and `req_ready` is all zero.
- **Arbitration.** Round-robin over the `req_valid` bits.
  - Search starts at `last_grant+1` and wraps modulo `NUM_REQ`.
  - `req_ready[g] = advance` for the first valid g found.
  - `last_grant` updates to g only on a request transfer.
  - `req_ready` depends combinationally on `req_valid` and `rsp_ready`. There are no other combinational input-to-output paths.
- **Issue.** The accepted a, b and id enter stage 1 with valid=1. When `advance` is 1 and no request is accepted, a bubble (valid=0) enters stage 1.
- **Bubbles are not squeezed.** A bubble occupies its stage like a real entry.
- **Datapath.** Identical to `fp_multiplier`:
  - sign = sa^sb.
  - exp = ea+eb-127, truncated to 8 bits.
  - 24x24 mantissa product with the hidden bit forced to 1.
  - If product[47] is set: mantissa = product[46:24] and exp+1. Otherwise mantissa = product[45:23].
  - Truncation only. No rounding, no special-case handling for zero, inf, NaN or denormals, no overflow saturation.
  - The core is instantiated once. Its output is registered in the first stage and carried through the remaining stages.
- **Outputs.** `rsp_valid`, `rsp_id` and `rsp_result` come from the last stage. `busy` is the OR of all stage valid bits.
- **Payload registers.** Stage registers hold their payload when `advance` is 0. Payload of invalid stages is don't-care, but `rsp_result` and `rsp_id` read 0 after reset until the first valid output.

## Timing

- **Reset values.**
  - `req_ready` = 0 while `rst` is high.
  - All stage valids = 0, so `rsp_valid` = 0 and `busy` = 0.
  - `rsp_id` = 0, `rsp_result` = 0.
  - `last_grant` = `NUM_REQ`-1, so requester 0 has highest priority on the first post-reset cycle.
- **Reset mid-operation.** Asserting `rst` discards all in-flight entries. No response is produced for them.
- **Latency.** A request accepted at cycle t gives `rsp_valid`=1 at cycle t+`MUL_LAT`, plus one cycle for every cycle `advance` is 0 in between.
- **Throughput.** One issue per cycle while `rsp_ready` stays 1.
- **Ordering.** Responses leave in issue order.
- **Stall.** `rsp_valid`=1 with `rsp_ready`=0 freezes the whole pipeline and blocks issue. This holds even if earlier stages contain bubbles.
- **Simultaneous events.** A response transfer and a request transfer may occur in the same cycle.
- **Requester stability.** A requester may drop `req_valid` without a transfer. The arbiter reevaluates every cycle and holds no lock.

## Test plan

1. **Basic multiply.** After reset (`MUL_LAT`=2), requester 2 alone sends a=0x40000000, b=0x40400000 with `rsp_ready`=1. Required: `req_ready`=4'b0100 in the same cycle; two cycles later `rsp_valid`=1, `rsp_id`=2, `rsp_result`=0x40C00000.
2. **Normalization and sign paths.**
   - 0x3FC00000 * 0x3FC00000 gives 0x40100000.
   - 0xC0000000 * 0x3F000000 gives 0xBF800000.
   - Both results appear on consecutive cycles with the correct ids.
3. **Round-robin fairness.** All 4 requesters hold `req_valid` for 8 cycles with `rsp_ready`=1. Required: grants in order 0,1,2,3,0,1,2,3; `rsp_id` follows the same sequence `MUL_LAT` cycles later.
4. **Backpressure.**
   - Hold `rsp_ready`=0 for 3 cycles while a result is valid. Required: `req_ready`=0, and `rsp_result`/`rsp_id` stay stable.
   - On release, pending results drain in order with no loss or duplication.
5. **Simultaneous transfer with bubble.** Issue only on even cycles. Required:
   - Response and request transfers coincide without disturbing each other.
   - Odd cycles show `rsp_valid`=0.
   - `busy` drops one cycle after the last result transfers.
6. **Reset mid-flight.** Assert `rst` for 1 cycle with 2 entries in flight. Required: no `rsp_valid` afterward, `busy`=0, and the next grant goes to requester 0.
